bnn_cmd_parser: RTL

//  Sequential successor to the combinational BNN command decoder: consumes the SPI-delivered byte

---
 rtl/bnn_cmd_parser.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bnn_cmd_parser.sv
// Byte-stream command parser for the BNN core: decodes opcodes, assembles payloads, issues writes.
// Optional BNN_CMD_CHECKSUM_EN adds a trailing XOR checksum byte per write command.
module bnn_cmd_parser #(
   parameter int unsigned IN_BYTES  = 1,
   parameter int unsigned WT_BYTES  = 2,
   parameter int unsigned BS_BYTES  = 2,
   parameter int unsigned MAX_BYTES = 4,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DEPTH     = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             byte_in,
   input  logic                   byte_valid,
   output logic                   byte_ready,
   output logic                   wr_en,
   output logic [2:0]             wr_sel,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [8*MAX_BYTES-1:0] wr_data,
   output logic                   start,
   output logic [3:0]             status
);

   localparam int unsigned DW = 8 * MAX_BYTES;
   localparam int unsigned CW = $clog2(MAX_BYTES + 1);

   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;

   state_t            state;
   logic [CW-1:0]     rem;
   logic [DW-1:0]     data;
   logic [2:0]        sel;
   logic [ADDR_W-1:0] cnt [3];
   logic              err_q, busy_q, wrap_q, done_q;

   logic              take;
   logic [DW-1:0]     data_shift;
   logic [1:0]        idx;
   logic [ADDR_W-1:0] cur_cnt;
   logic              last_addr;
   logic              last_byte;
   logic              go_commit;
   logic [DW-1:0]     commit_data;

   assign take       = byte_valid && byte_ready;
   assign data_shift = (data << 8) | DW'(byte_in);
   assign idx        = sel[2] ? 2'd2 : (sel[1] ? 2'd1 : 2'd0);
   assign cur_cnt    = cnt[idx];
   assign last_addr  = (cur_cnt == ADDR_W'(DEPTH - 1));
   assign last_byte  = (state == S_PAYLOAD) && take && (rem == CW'(1));
   assign status     = {err_q, busy_q, wrap_q, done_q};

`ifdef BNN_CMD_CHECKSUM_EN
   logic [7:0] csum;
   logic       sum_ok;
   assign sum_ok      = (byte_in == csum);
   assign go_commit   = (state == S_CHECK) && take && sum_ok;
   assign commit_data = data;
`else
   assign go_commit   = last_byte;
   assign commit_data = data_shift;
`endif

   // Single-process FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rem        <= '0;
         data       <= '0;
         sel        <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         byte_ready <= 1'b1;
         wr_en      <= 1'b0;
         wr_sel     <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         start      <= 1'b0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
`ifdef BNN_CMD_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         wr_en  <= 1'b0;
         start  <= 1'b0;
         done_q <= 1'b0;
         if (go_commit) begin
            state      <= S_COMMIT;
            busy_q     <= 1'b1;
            byte_ready <= 1'b0;
            wr_en      <= 1'b1;
            wr_sel     <= sel;
            wr_addr    <= cur_cnt;
            wr_data    <= commit_data;
            done_q     <= 1'b1;
            cnt[idx]   <= last_addr ? '0 : cur_cnt + ADDR_W'(1);
            if (last_addr) wrap_q <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (take) begin
                     case (byte_in)
                        8'hB1, 8'hB2, 8'hB3: begin
                           state  <= S_PAYLOAD;
                           busy_q <= 1'b1;
                           data   <= '0;
`ifdef BNN_CMD_CHECKSUM_EN
                           csum   <= byte_in;
`endif
                           case (byte_in)
                              8'hB1:   begin sel <= 3'b001; rem <= CW'(IN_BYTES); end
                              8'hB2:   begin sel <= 3'b010; rem <= CW'(WT_BYTES); end
                              default: begin sel <= 3'b100; rem <= CW'(BS_BYTES); end
                           endcase
                        end
                        8'hB4: start <= 1'b1;
                        8'hB0: begin
                           for (int i = 0; i < 3; i++) cnt[i] <= '0;
                           wrap_q <= 1'b0;
                        end
                        8'h00: ;
                        default: err_q <= 1'b1;
                     endcase
                  end
               end
               S_PAYLOAD: begin
                  if (take) begin
                     data <= data_shift;
                     rem  <= rem - CW'(1);
`ifdef BNN_CMD_CHECKSUM_EN
                     csum <= csum ^ byte_in;
                     if (last_byte) state <= S_CHECK;
`endif
                  end
               end
`ifdef BNN_CMD_CHECKSUM_EN
               // Only a bad checksum reaches here; a good one takes the commit path above.
               S_CHECK: begin
                  if (take) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     err_q  <= 1'b1;
                  end
               end
`endif
               default: begin
                  state      <= S_IDLE;
                  busy_q     <= 1'b0;
                  byte_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
